// File: rtl/lbist_pkg.sv
// Shared types and sizing helpers for the LBIST signature controller.
package lbist_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } lbist_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lbist_cnt.sv
// Up-counter from 0 that stops at TC; tc flags the terminal count.
module lbist_cnt #(
    parameter int TC = 0,
    parameter int W  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (en && !tc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == W'(TC));

endmodule

// File: rtl/lbist_sig_ctrl.sv
// LBIST run sequencer: seeds the MISR, alternates shift/capture windows and checks the signature.
// Define LBIST_SIG_DUMP_EN to expose the latched signature (sig_q) and live pattern index (pat_cnt).
module lbist_sig_ctrl
    import lbist_pkg::*;
#(
    parameter int               SCAN_LEN           = 35,
    parameter int               N_PATTERNS         = 1024,
    parameter int               SIG_W              = 240,
    parameter logic [SIG_W-1:0] EXPECTED_SIGNATURE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] sig,
    output logic             misr_rst_n,
    output logic             misr_en,
    output logic             scan_en,
    output logic             busy,
    output logic             done,
`ifdef LBIST_SIG_DUMP_EN
    output logic             pass,
    output logic [SIG_W-1:0] sig_q,
    output logic [cnt_w(N_PATTERNS)-1:0] pat_cnt
`else
    output logic             pass
`endif
);

    localparam int SHIFT_W = cnt_w(SCAN_LEN);
    localparam int PAT_W   = cnt_w(N_PATTERNS);

    lbist_state_t r_state;
    lbist_state_t w_state_next;

    logic               r_unload;
    logic               r_first_win;
    logic               r_misr_rst_n;
    logic               r_misr_en;
    logic               r_scan_en;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic               w_shift_load;
    logic               w_shift_en;
    logic               w_shift_tc;
    logic [SHIFT_W-1:0] w_shift_cnt;
    logic               w_pat_load;
    logic               w_pat_en;
    logic               w_pat_tc;
    logic [PAT_W-1:0]   w_pat_cnt;
    logic               w_misr_en_next;
    logic               w_busy_next;

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (start) w_state_next = ST_SEED;
                ST_SEED:    w_state_next = ST_SHIFT;
                ST_SHIFT:   if (w_shift_tc) w_state_next = r_unload ? ST_COMPARE : ST_CAPTURE;
                ST_CAPTURE: w_state_next = ST_SHIFT;
                ST_COMPARE: w_state_next = ST_DONE;
                ST_DONE:    if (start) w_state_next = ST_SEED;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_shift_load = (w_state_next == ST_SHIFT) && (r_state != ST_SHIFT);
    assign w_shift_en   = (r_state == ST_SHIFT);
    assign w_pat_load   = (w_state_next == ST_SEED);
    assign w_pat_en     = (r_state == ST_CAPTURE);

    lbist_cnt #(
        .TC (SCAN_LEN - 1),
        .W  (SHIFT_W)
    ) u_shift_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_shift_load),
        .en    (w_shift_en),
        .cnt   (w_shift_cnt),
        .tc    (w_shift_tc)
    );

    lbist_cnt #(
        .TC (N_PATTERNS - 1),
        .W  (PAT_W)
    ) u_pat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_pat_load),
        .en    (w_pat_en),
        .cnt   (w_pat_cnt),
        .tc    (w_pat_tc)
    );

    // The first window only loads the chains, so its unload data is not compacted.
    assign w_misr_en_next = (w_state_next == ST_SHIFT) && !(r_first_win && (r_state != ST_CAPTURE));
    assign w_busy_next    = (w_state_next == ST_SEED)    || (w_state_next == ST_SHIFT) ||
                            (w_state_next == ST_CAPTURE) || (w_state_next == ST_COMPARE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_unload    <= 1'b0;
            r_first_win <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ST_SEED) begin
                r_unload    <= 1'b0;
                r_first_win <= 1'b1;
            end else if (r_state == ST_CAPTURE) begin
                r_first_win <= 1'b0;
                if (w_pat_tc) begin
                    r_unload <= 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misr_rst_n <= 1'b1;
            r_misr_en    <= 1'b0;
            r_scan_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_misr_rst_n <= (w_state_next != ST_SEED);
            r_misr_en    <= w_misr_en_next;
            r_scan_en    <= (w_state_next == ST_SHIFT);
            r_busy       <= w_busy_next;
            r_done       <= (w_state_next == ST_DONE);
            if (w_state_next != ST_DONE) begin
                r_pass <= 1'b0;
            end else if (r_state == ST_COMPARE) begin
                r_pass <= (sig == EXPECTED_SIGNATURE);
            end
        end
    end

    assign misr_rst_n = r_misr_rst_n;
    assign misr_en    = r_misr_en;
    assign scan_en    = r_scan_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;

`ifdef LBIST_SIG_DUMP_EN
    logic [SIG_W-1:0] r_sig_q;
    logic             w_unused_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_q <= '0;
        end else if (r_state == ST_COMPARE) begin
            r_sig_q <= sig;
        end
    end

    assign sig_q        = r_sig_q;
    assign pat_cnt      = w_pat_cnt;
    assign w_unused_cnt = ^w_shift_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{w_shift_cnt, w_pat_cnt};
`endif

endmodule

// File: doc/lbist_sig_ctrl.md
LBIST_SIG_CTRL -- requirements
Module: lbist_sig_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_LEN, default 35; it is the number of shift cycles per scan window.
REQ-002 The block SHALL have parameter N_PATTERNS, default 1024; it is the number of capture patterns per run.
REQ-003 The block SHALL have parameter SIG_W, default 240; it is the MISR bank signature width.
REQ-004 The block SHALL have parameter EXPECTED_SIGNATURE, default 0; it is the golden signature.
REQ-005 The block SHALL have port clk, input, 1 bit; single clock for all state.
REQ-006 The block SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-007 The block SHALL have port start, input, 1 bit; run request, sampled on the rising clk edge.
REQ-008 The block SHALL have port abort, input, 1 bit; terminates the run.
REQ-009 The block SHALL have port sig, input, SIG_W bits; MISR bank output.
REQ-010 The block SHALL have port misr_rst_n, output, 1 bit; synchronous MISR clear to seed, active-low.
REQ-011 The block SHALL have port misr_en, output, 1 bit; MISR compaction enable.
REQ-012 The block SHALL have port scan_en, output, 1 bit; scan chains in shift mode.
REQ-013 The block SHALL have ports busy, done and pass as outputs, 1 bit each; status.

Function
REQ-014 The FSM SHALL have states IDLE, SEED, SHIFT, CAPTURE, COMPARE and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to SEED; otherwise the FSM SHALL stay in IDLE.
REQ-016 SEED SHALL last 1 cycle with misr_rst_n=0, then move to SHIFT.
REQ-017 SHIFT SHALL last exactly SCAN_LEN cycles with scan_en=1.
- misr_en=1 in every SHIFT window except the first, because the chain contents are unknown before the first load.
REQ-018 CAPTURE SHALL last 1 cycle with scan_en=0 and misr_en=0.
REQ-019 Sequencing SHALL be (SHIFT, CAPTURE) repeated N_PATTERNS times, then one final unload SHIFT, then COMPARE.
- Total: N_PATTERNS+1 shift windows.
REQ-020 COMPARE SHALL last 1 cycle and register pass = (sig == EXPECTED_SIGNATURE), then move to DONE.
REQ-021 DONE SHALL hold done=1 and the pass value until start or abort.
- start in DONE: go to SEED and clear done and pass in the same edge.
REQ-022 busy SHALL be 1 in SEED, SHIFT, CAPTURE and COMPARE; 0 otherwise.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 abort=1 in any state other than IDLE SHALL move the FSM to IDLE on the next edge and clear done and pass.
- abort has priority over start and over every state transition.
REQ-025 Shift and pattern counters SHALL be $clog2-sized and wrap-free.
- Each counter reloads on entry to its window.
- Terminal counts: SCAN_LEN-1 and N_PATTERNS-1.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On rst_n=0, regardless of the mid-run state, the block SHALL asynchronously force the following values, and all counters SHALL clear:

| Signal | Reset value |
|---|---|
| state | IDLE |
| misr_rst_n | 1 |
| misr_en | 0 |
| scan_en | 0 |
| busy | 0 |
| done | 0 |
| pass | 0 |

Configuration
REQ-028 With macro LBIST_SIG_DUMP_EN defined, the block SHALL add the following outputs, both reset to 0:
- sig_q (SIG_W bits): sig as latched in COMPARE.
- pat_cnt: the live pattern index.
REQ-029 Without LBIST_SIG_DUMP_EN, those ports and registers SHALL NOT exist, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package lbist_pkg SHALL hold:
- the FSM state enum typedef;
- the shared width constants.
REQ-031 The two counters SHALL be instances of one sub-module, lbist_cnt, with this interface:
- parameterised terminal count;
- load input;
- enable input;
- tc output.

Verification (SCAN_LEN=4, N_PATTERNS=3, EXPECTED_SIGNATURE=0xABC)
REQ-032 Nominal pass run:
- Stimulus: start pulse at edge 0, sig held at 0xABC.
- misr_rst_n=0 in cycle 1.
- 16 scan_en=1 cycles and 3 CAPTURE cycles in cycles 2-20.
- COMPARE in cycle 21.
- done=1 and pass=1 from cycle 22.
REQ-033 misr_en gating: misr_en SHALL be 0 for the first 4 SHIFT cycles and 1 for the remaining 12.
REQ-034 Fail: sig=0xABD at COMPARE -> done=1, pass=0.
REQ-035 Abort: abort in cycle 10 -> IDLE at cycle 11, with busy=0, done=0 and scan_en=0; a later start then gives a full 21-cycle run.
REQ-036 Start while busy: start in cycle 5 SHALL be ignored, and done SHALL still rise at cycle 22.
REQ-037 Reset and restart:
- rst_n asserted in cycle 12 -> all outputs at their reset values immediately.
- start in DONE -> done and pass clear on the next edge, and a new run begins.
